// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: d = a - b - bin over WIDTH bits, STEP bits per clock,
// with a start/busy/done handshake. WIDTH must be a multiple of STEP.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; results from the last operation are held
//   RUN   | one STEP-bit slice processed per clock, LSB chunk first
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             zero
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic [STEP-1:0]  slice_d;
  logic             slice_bo;
  logic             br_c;
  logic [WIDTH-1:0] r_next;

  // Ripple of full-subtractor cells across the current STEP-bit slice.
  always_comb begin
    br_c    = br;
    slice_d = '0;
    for (int i = 0; i < STEP; i++) begin
      slice_d[i] = a_sr[i] ^ b_sr[i] ^ br_c;
      br_c       = (~a_sr[i] & b_sr[i]) | (~(a_sr[i] ^ b_sr[i]) & br_c);
    end
    slice_bo = br_c;
  end

  // New slice enters at the top; after N chunks the LSB chunk sits at bit 0.
  assign r_next = WIDTH'({slice_d, r_sr} >> STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bo    <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> STEP;
          b_sr <= b_sr >> STEP;
          r_sr <= r_next;
          br   <= slice_bo;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_CHUNK) begin
            d     <= r_next;
            bo    <= slice_bo;
            zero  <= (r_next == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor across several WIDTH/STEP
// configurations sharing one clock, reset and operand bus.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  start_v = '0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        bin_in = 1'b0;

  logic [7:0]  busy_v;
  logic [7:0]  done_v;
  logic [7:0]  bo_v;
  logic [7:0]  zero_v;
  logic [15:0] d_v [8];

  logic [0:0]  d0;
  logic [7:0]  d1, d2, d3;
  logic [15:0] d4, d5, d6, d7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(1),  .STEP(1))  u_w1_s1 (.clk(clk), .rst(rst), .start(start_v[0]),
    .a(a_in[0:0]), .b(b_in[0:0]), .bin(bin_in), .busy(busy_v[0]), .done(done_v[0]), .d(d0), .bo(bo_v[0]), .zero(zero_v[0]));
  serial_subtractor #(.WIDTH(8),  .STEP(1))  u_w8_s1 (.clk(clk), .rst(rst), .start(start_v[1]),
    .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in), .busy(busy_v[1]), .done(done_v[1]), .d(d1), .bo(bo_v[1]), .zero(zero_v[1]));
  serial_subtractor #(.WIDTH(8),  .STEP(4))  u_w8_s4 (.clk(clk), .rst(rst), .start(start_v[2]),
    .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in), .busy(busy_v[2]), .done(done_v[2]), .d(d2), .bo(bo_v[2]), .zero(zero_v[2]));
  serial_subtractor #(.WIDTH(8),  .STEP(8))  u_w8_s8 (.clk(clk), .rst(rst), .start(start_v[3]),
    .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in), .busy(busy_v[3]), .done(done_v[3]), .d(d3), .bo(bo_v[3]), .zero(zero_v[3]));
  serial_subtractor #(.WIDTH(16), .STEP(1))  u_w16_s1 (.clk(clk), .rst(rst), .start(start_v[4]),
    .a(a_in), .b(b_in), .bin(bin_in), .busy(busy_v[4]), .done(done_v[4]), .d(d4), .bo(bo_v[4]), .zero(zero_v[4]));
  serial_subtractor #(.WIDTH(16), .STEP(2))  u_w16_s2 (.clk(clk), .rst(rst), .start(start_v[5]),
    .a(a_in), .b(b_in), .bin(bin_in), .busy(busy_v[5]), .done(done_v[5]), .d(d5), .bo(bo_v[5]), .zero(zero_v[5]));
  serial_subtractor #(.WIDTH(16), .STEP(4))  u_w16_s4 (.clk(clk), .rst(rst), .start(start_v[6]),
    .a(a_in), .b(b_in), .bin(bin_in), .busy(busy_v[6]), .done(done_v[6]), .d(d6), .bo(bo_v[6]), .zero(zero_v[6]));
  serial_subtractor #(.WIDTH(16), .STEP(16)) u_w16_s16 (.clk(clk), .rst(rst), .start(start_v[7]),
    .a(a_in), .b(b_in), .bin(bin_in), .busy(busy_v[7]), .done(done_v[7]), .d(d7), .bo(bo_v[7]), .zero(zero_v[7]));

  assign d_v[0] = {15'b0, d0};
  assign d_v[1] = {8'b0, d1};
  assign d_v[2] = {8'b0, d2};
  assign d_v[3] = {8'b0, d3};
  assign d_v[4] = d4;
  assign d_v[5] = d5;
  assign d_v[6] = d6;
  assign d_v[7] = d7;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One operation on instance idx; latency counted in clocks from the accepting edge.
  task automatic run_op(input int idx, input logic [15:0] av, input logic [15:0] bv,
                        input logic binv, input int exp_lat,
                        input logic [15:0] exp_d, input logic exp_bo);
    int lat;
    @(negedge clk);
    a_in = av; b_in = bv; bin_in = binv;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    chk($sformatf("busy_after_accept[%0d]", idx), 32'(busy_v[idx]), 32'd1);
    lat = 0;
    while (done_v[idx] !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency[%0d]", idx), 32'(lat), 32'(exp_lat));
    chk($sformatf("d[%0d] a=%0h b=%0h bin=%0b", idx, av, bv, binv), 32'(d_v[idx]), 32'(exp_d));
    chk($sformatf("bo[%0d] a=%0h b=%0h bin=%0b", idx, av, bv, binv), 32'(bo_v[idx]), 32'(exp_bo));
    chk($sformatf("zero[%0d]", idx), 32'(zero_v[idx]), 32'(exp_d == 16'h0));
    chk($sformatf("busy_at_done[%0d]", idx), 32'(busy_v[idx]), 32'd0);
    @(negedge clk);
    chk($sformatf("done_one_cycle[%0d]", idx), 32'(done_v[idx]), 32'd0);
  endtask

  logic [7:0]  oa [45];
  logic [7:0]  ob [45];
  logic        oc [45];
  logic [8:0]  diff9;
  logic [16:0] diff17;
  logic [15:0] ra, rb;
  logic        rc;
  logic        seen_done;
  int          lat_tab [8];
  // Hand-derived full-subtractor truth table, indexed by {a, b, bin}.
  logic [7:0]  fs_d  = 8'b1001_0110;
  logic [7:0]  fs_bo = 8'b1000_1110;

  initial begin
    lat_tab[4] = 16; lat_tab[5] = 8; lat_tab[6] = 4; lat_tab[7] = 1;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy_v), 32'h0);
    chk("reset_done", 32'(done_v), 32'h0);
    chk("reset_bo",   32'(bo_v),   32'h0);
    chk("reset_zero", 32'(zero_v), 32'h0);
    chk("reset_d1",   32'(d_v[1]), 32'h0);
    chk("reset_d4",   32'(d_v[4]), 32'h0);
    rst = 1'b0;

    // Full-subtractor truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op(0, {15'b0, v[2]}, {15'b0, v[1]}, v[0], 1, {15'b0, fs_d[i]}, fs_bo[i]);
    end

    // WIDTH=8 directed
    run_op(1, 16'h05, 16'h03, 1'b0, 8, 16'h02, 1'b0);
    run_op(1, 16'h00, 16'h01, 1'b0, 8, 16'hFF, 1'b1);
    run_op(1, 16'h80, 16'h7F, 1'b1, 8, 16'h00, 1'b0);
    run_op(2, 16'h3C, 16'hC3, 1'b1, 2, 16'h78, 1'b1);
    run_op(3, 16'h3C, 16'hC3, 1'b1, 1, 16'h78, 1'b1);

    // Continuous start with changing operands: accepts every 9 clocks
    for (int e = 0; e < 45; e++) begin
      oa[e] = 8'(e * 37 + 11);
      ob[e] = 8'(e * 91 + 5);
      oc[e] = 1'(e);
      a_in = {8'h0, oa[e]}; b_in = {8'h0, ob[e]}; bin_in = oc[e];
      start_v[1] = 1'b1;
      @(negedge clk);
      chk($sformatf("hs_busy e=%0d", e), 32'(busy_v[1]), 32'((e % 9) != 8));
      chk($sformatf("hs_done e=%0d", e), 32'(done_v[1]), 32'((e % 9) == 8));
      if ((e % 9) == 8) begin
        diff9 = {1'b0, oa[e-8]} - {1'b0, ob[e-8]} - {8'b0, oc[e-8]};
        chk($sformatf("hs_d e=%0d", e),  32'(d_v[1]), 32'(diff9[7:0]));
        chk($sformatf("hs_bo e=%0d", e), 32'(bo_v[1]), 32'(diff9[8]));
      end
    end
    start_v[1] = 1'b0;
    @(negedge clk);

    // Reset mid-operation: previous result must be wiped, no done afterwards
    run_op(1, 16'h05, 16'h03, 1'b0, 8, 16'h02, 1'b0);
    @(negedge clk);
    a_in = 16'hFF; b_in = 16'h01; bin_in = 1'b0;
    start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy_v[1]), 32'd0);
    chk("rst_done", 32'(done_v[1]), 32'd0);
    chk("rst_d",    32'(d_v[1]),    32'd0);
    chk("rst_bo",   32'(bo_v[1]),   32'd0);
    chk("rst_zero", 32'(zero_v[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[1] === 1'b1) seen_done = 1'b1;
    end
    chk("no_done_after_reset", 32'(seen_done), 32'd0);
    run_op(1, 16'h10, 16'h01, 1'b0, 8, 16'h0F, 1'b0);

    // Random regression at WIDTH=16 across four step sizes
    for (int i = 0; i < 1000; i++) begin
      int idx;
      idx = 4 + (i % 4);
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rc = 1'($urandom_range(0, 1));
      diff17 = {1'b0, ra} - {1'b0, rb} - {16'b0, rc};
      run_op(idx, ra, rb, rc, lat_tab[idx], diff17[15:0], diff17[16]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
